// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the load/store + writeback stage.
//   - RV32I load/store opcodes and funct3 codes
//   - FSM state encoding used by mem_stage (also exported on state_dbg)
package mem_stage_pkg;

    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S = 7'b0100011;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// mem_align: purely combinational lane handling for byte/half/word accesses.
// Ports:
//   we, funct3, addr[1:0]  access kind and byte offset
//   wdata                  raw store data (rs2)
//   rdata                  raw bus read data
//   be                     byte enables (loads always 4'b1111)
//   lane_wdata             store data replicated onto every lane
//   load_data              selected and sign/zero-extended load value
//   bad                    illegal funct3 or misaligned address
module mem_align
    import mem_stage_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata;
        load_data  = rdata;
        bad        = 1'b0;
        if (we) begin
            case (funct3)
                INST_SB: begin
                    be         = 4'b0001 << addr;
                    lane_wdata = {4{wdata[7:0]}};
                end
                INST_SH: begin
                    be         = addr[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{wdata[15:0]}};
                    bad        = addr[0];
                end
                INST_SW: bad = |addr;
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                INST_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
                INST_LBU: load_data = {24'd0, byte_sel};
                INST_LH: begin
                    load_data = {{16{half_sel[15]}}, half_sel};
                    bad       = addr[0];
                end
                INST_LHU: begin
                    load_data = {16'd0, half_sel};
                    bad       = addr[0];
                end
                INST_LW:  bad = |addr;
                default:  bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store + writeback stage after execute.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_addr_i/rd_data_i/rd_wen_i   writeback request from execute
//   mem_req_i, mem_we_i, mem_funct3_i, mem_addr_i, mem_wdata_i  memory request
//   bus_req_o/we_o/addr_o/be_o/wdata_o, bus_gnt_i, bus_rvalid_i, bus_rdata_i  data bus
//   rd_addr_o/rd_data_o/rd_wen_o   registered writeback to the register file
//   hold_flag_o              stall request while an access is in flight
//   err_o                    one-cycle pulse on misaligned/illegal/timeout
//   state_dbg                current FSM state
// Bus handshake: bus_req_o is held with stable addr/we/be/wdata until a cycle
// with bus_gnt_i high; the response is the first bus_rvalid_i seen in WAIT
// (never in the grant cycle itself).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic        hold_flag_o,
    output logic        err_o,
    output logic [1:0]  state_dbg
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    mem_state_t  state, state_next;
    logic [CNT_W-1:0] cnt;

    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [4:0]  lat_rd_addr;
    logic        lat_rd_wen;

    logic        in_idle, in_req;
    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_lane_wdata;
    logic [31:0] al_load;
    logic        al_bad;

    logic        start, bad_req, rv_done, to_done, timeout_hit;

    assign in_idle = (state == MEM_IDLE);
    assign in_req  = (state == MEM_REQ);

    // One aligner serves both the legality check of the incoming request (IDLE)
    // and the lane work of the latched access (REQ/WAIT).
    assign al_we     = in_idle ? mem_we_i          : lat_we;
    assign al_funct3 = in_idle ? mem_funct3_i      : lat_funct3;
    assign al_addr   = in_idle ? mem_addr_i[1:0]   : lat_addr[1:0];
    assign al_wdata  = in_idle ? mem_wdata_i       : lat_wdata;

    mem_align u_align (
        .we         (al_we),
        .funct3     (al_funct3),
        .addr       (al_addr),
        .wdata      (al_wdata),
        .rdata      (bus_rdata_i),
        .be         (al_be),
        .lane_wdata (al_lane_wdata),
        .load_data  (al_load),
        .bad        (al_bad)
    );

    // The counter equals the number of completed WAIT cycles, so it reaches
    // TIMEOUT at the edge that closes the cycle where it holds TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_next  = state;
        hold_flag_o = 1'b0;
        bus_req_o   = 1'b0;
        start       = 1'b0;
        bad_req     = 1'b0;
        rv_done     = 1'b0;
        to_done     = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (mem_req_i) begin
                    if (al_bad) begin
                        bad_req = 1'b1;
                    end else begin
                        start       = 1'b1;
                        hold_flag_o = 1'b1;
                        state_next  = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                bus_req_o   = 1'b1;
                hold_flag_o = 1'b1;
                if (bus_gnt_i) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                hold_flag_o = 1'b1;
                if (bus_rvalid_i) begin
                    rv_done     = 1'b1;
                    hold_flag_o = 1'b0;
                    state_next  = MEM_IDLE;
                end else if (timeout_hit) begin
                    to_done     = 1'b1;
                    hold_flag_o = 1'b0;
                    state_next  = MEM_IDLE;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    // Bus fields are only meaningful while requesting; zero them otherwise.
    assign bus_we_o    = in_req & lat_we;
    assign bus_addr_o  = in_req ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign bus_be_o    = in_req ? al_be : 4'd0;
    assign bus_wdata_o = in_req ? al_lane_wdata : 32'd0;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MEM_IDLE;
            cnt         <= '0;
            err_o       <= 1'b0;
            rd_addr_o   <= 5'd0;
            rd_data_o   <= 32'd0;
            rd_wen_o    <= 1'b0;
            lat_we      <= 1'b0;
            lat_funct3  <= 3'd0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            lat_rd_addr <= 5'd0;
            lat_rd_wen  <= 1'b0;
        end else begin
            state <= state_next;
            err_o <= bad_req | to_done;

            if (start) begin
                lat_we      <= mem_we_i;
                lat_funct3  <= mem_funct3_i;
                lat_addr    <= mem_addr_i;
                lat_wdata   <= mem_wdata_i;
                lat_rd_addr <= rd_addr_i;
                lat_rd_wen  <= rd_wen_i;
            end

            if (in_req && bus_gnt_i) cnt <= '0;
            else if (state == MEM_WAIT) cnt <= cnt + 1'b1;

            case (state)
                MEM_IDLE: begin
                    if (mem_req_i) begin
                        rd_wen_o <= 1'b0;
                    end else begin
                        rd_addr_o <= rd_addr_i;
                        rd_data_o <= rd_data_i;
                        rd_wen_o  <= rd_wen_i && (rd_addr_i != 5'd0);
                    end
                end
                MEM_WAIT: begin
                    if (rv_done) begin
                        rd_addr_o <= lat_rd_addr;
                        if (!lat_we) rd_data_o <= al_load;
                        rd_wen_o  <= !lat_we && lat_rd_wen && (lat_rd_addr != 5'd0);
                    end else begin
                        rd_wen_o <= 1'b0;
                    end
                end
                default: rd_wen_o <= 1'b0;
            endcase
        end
    end

endmodule
